// File: rtl/mem_block_responder.sv
// rtl/mem_block_responder.sv - backing memory responder: programmable latency, block reads, single-word writes
module mem_block_responder #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 4,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_last,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int WIDX_W = ADDR_WIDTH - 2;
  localparam int WORDS  = 1 << WIDX_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int BASE_W = WIDX_W - BEAT_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            lat_q, lat_d;
  logic [BASE_W-1:0]     base_q, base_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [BEAT_W-1:0]     beat_nxt;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           rd_cnt_q, rd_cnt_d;
  logic [15:0]           wr_cnt_q, wr_cnt_d;
  logic                  accept;
  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  // Byte offset within a word is never used.
  logic unused_addr;
  assign unused_addr = ^req_addr[1:0];

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = valid_q;
  assign resp_data  = data_q;
  assign resp_last  = last_q;
  assign rd_count   = rd_cnt_q;
  assign wr_count   = wr_cnt_q;
  assign beat_nxt   = beat_q + 1'b1;

  // Next-state logic: accept, latency countdown, then beats in block order.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    base_d   = base_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    beat_d   = beat_q;
    valid_d  = valid_q;
    last_d   = last_q;
    data_d   = data_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    accept   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = S_WAIT;
          lat_d   = 4'(LATENCY - 1);
          base_d  = req_addr[ADDR_WIDTH-1 -: BASE_W];
          wr_d    = req_write;
          wdata_d = req_wdata;
          if (req_write) begin
            if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
          end else begin
            if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
          end
        end
      end
      S_WAIT: begin
        if (lat_q == 4'd0) begin
          state_d = S_RESP;
          beat_d  = '0;
          valid_d = 1'b1;
          if (wr_q) begin
            data_d = wdata_q;
            last_d = 1'b1;
          end else begin
            data_d = mem_q[{base_q, {BEAT_W{1'b0}}}];
            last_d = (BEATS == 1);
          end
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          if (last_q) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            beat_d = beat_nxt;
            data_d = mem_q[{base_q, beat_nxt}];
            last_d = (beat_nxt == BEAT_W'(BEATS - 1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and response registers; reset aborts any response in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lat_q    <= '0;
      base_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      base_q   <= base_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      data_q   <= data_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Storage: each word resets to its own byte address; writes commit on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= DATA_WIDTH'(i << 2);
    end else if (accept && req_write) begin
      mem_q[req_addr[ADDR_WIDTH-1:2]] <= req_wdata;
    end
  end

endmodule
